// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing derivation, frame shape.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   // Clock cycles per bit period (integer division, truncates).
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Offset from the detected start edge to the middle of the start bit.
   function automatic int half_bit(input int clk_freq, input int baud);
      return clks_per_bit(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through FIFO; head entry is combinational from the array.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push into a full FIFO without a same-cycle pop is dropped and overrun pulses.
//
// Ports: clk, rst_n (async, active-low); push/push_data write side;
//        pop read side (ignored while empty); head/empty status; overrun one-cycle pulse.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = DATA_BITS,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             overrun
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // A same-cycle pop frees the slot the push lands in, so full+pop still accepts.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         overrun <= push && !do_push;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver feeding a small FWFT receive FIFO.
// Latency: byte valid on rx_data the cycle after the mid-stop-bit sample (~9.5 bit times + 4 cycles after pin fall).
// Backpressure: rx_ready pops the FIFO; a good byte arriving while the FIFO is full is dropped with an overrun pulse.
//
// Ports: clk, rst_n (async, active-low); rx serial input (idle high, asynchronous);
//        rx_data/rx_valid/rx_ready FIFO read side; frame_err, overrun one-cycle pulses;
//        busy high while a frame is being received.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 40000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

   rx_state_e            state;
   rx_state_e            state_d;
   logic [CNT_W-1:0]     bit_cnt;
   logic [CNT_W-1:0]     cnt_d;
   logic [2:0]           bit_idx;
   logic [2:0]           idx_d;
   logic [DATA_BITS-1:0] sh;
   logic [DATA_BITS-1:0] sh_d;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 rx_prev;
   logic                 push;
   logic                 ferr_d;
   logic                 fifo_empty;

   // --------------------------------------------------------------------
   // State register, synchronizer and edge tracker
   // --------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         sh        <= '0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         rx_prev   <= rx_s;
         state     <= state_d;
         bit_cnt   <= cnt_d;
         bit_idx   <= idx_d;
         sh        <= sh_d;
         frame_err <= ferr_d;
      end
   end

   // --------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------
   always_comb begin
      state_d = state;
      cnt_d   = bit_cnt + CNT_ONE;
      idx_d   = bit_idx;
      sh_d    = sh;
      push    = 1'b0;
      ferr_d  = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_d = '0;
            // Edge-triggered start: a held-low line (break) cannot retrigger.
            if (rx_prev && !rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (bit_cnt == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               // Line back high at mid-start-bit means it was a glitch.
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_cnt == CNT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh[DATA_BITS-1:1]};
               idx_d = bit_idx + 3'd1;
               if (bit_idx == IDX_LAST) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            if (bit_cnt == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  push = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state != IDLE);
   assign rx_valid = !fifo_empty;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (sh),
      .pop       (rx_ready),
      .head      (rx_data),
      .empty     (fifo_empty),
      .overrun   (overrun)
   );

endmodule
